// File: rtl/leaf_request_queue.sv
// Dual-port leaf result buffer serialised into one in-order request stream.
// Define LEAF_REQ_TAG_EN to build the per-port sequence tag counters.
module leaf_request_queue #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     leaf_en,
  input  logic [ADDRESS_WIDTH-1:0] leaf_index,
  input  logic                     leaf_two_en,
  input  logic [ADDRESS_WIDTH-1:0] leaf_index_two,
  output logic                     req_valid,
  output logic [ADDRESS_WIDTH-1:0] req_index,
  output logic                     req_port,
  output logic [TAG_WIDTH-1:0]     req_tag,
  input  logic                     req_ready,
  output logic                     in_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            two_ptr;
  logic [ADDRESS_WIDTH-1:0] idx_mem [DEPTH];
  logic [DEPTH-1:0]         port_mem;
  logic [CW-1:0]            free;
  logic                     acc_one;
  logic                     acc_two;
  logic                     drop;
  logic                     pop;
  logic [1:0]               n_push;

  // free is taken before the pop so a pop never makes room this cycle
  assign free      = CW'(DEPTH) - count;
  assign in_ready  = (free >= CW'(2));
  assign req_valid = (count != '0);
  assign pop       = req_valid && req_ready;

  assign acc_one = leaf_en && (free != '0);
  assign acc_two = leaf_two_en &&
                   (leaf_en ? (free >= CW'(2)) : (free != '0));
  assign drop    = (leaf_en && !acc_one) ||
                   (leaf_two_en && !acc_two);
  assign n_push  = {1'b0, acc_one} + {1'b0, acc_two};
  assign two_ptr = acc_one ? wr_ptr + PW'(1) : wr_ptr;

  assign req_index = idx_mem[rd_ptr];
  assign req_port  = port_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(n_push) - CW'(pop);
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (acc_one) begin
        idx_mem[wr_ptr]  <= leaf_index;
        port_mem[wr_ptr] <= 1'b0;
      end
      if (acc_two) begin
        idx_mem[two_ptr]  <= leaf_index_two;
        port_mem[two_ptr] <= 1'b1;
      end
    end
  end

`ifdef LEAF_REQ_TAG_EN
  logic [TAG_WIDTH-1:0] tag_one_q;
  logic [TAG_WIDTH-1:0] tag_two_q;
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];

  assign req_tag = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_one_q <= '0;
      tag_two_q <= '0;
    end else begin
      if (acc_one)
        tag_one_q <= tag_one_q + TAG_WIDTH'(1);
      if (acc_two)
        tag_two_q <= tag_two_q + TAG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (acc_one)
        tag_mem[wr_ptr] <= tag_one_q;
      if (acc_two)
        tag_mem[two_ptr] <= tag_two_q;
    end
  end
`else
  assign req_tag = '0;
`endif

endmodule
